vector_serializer: RTL
======================

Name: vector_serializer

Overview:
Downstream consumer of the parallel-vector FIFO. Takes one IN_NUM-element vector per valid/ready handshake and emits it as IN_NUM/OUT_NUM consecutive chunks of OUT_NUM elements, each on its own valid/ready handshake. It lets a wide buffered stream feed a narrower datapath, such as a reduced-parallelism linear or activation core, without losing throughput.

Parameters:
DATA_WIDTH, 8, bit width of one element
IN_NUM, 8, elements per input vector
OUT_NUM, 2, elements per output chunk; IN_NUM % OUT_NUM must be 0, otherwise elaboration fails via $error
RATIO, IN_NUM/OUT_NUM (localparam), chunks per vector

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset; low = reset
data_in  input  [DATA_WIDTH-1:0] x IN_NUM (unpacked)  input vector
data_in_valid  input  1  input vector valid
data_in_ready  output  1  block can accept a vector this cycle
data_out  output  [DATA_WIDTH-1:0] x OUT_NUM (unpacked)  current chunk
data_out_valid  output  1  chunk valid
data_out_ready  input  1  downstream accepts chunk
data_out_last  output  1  high with the final chunk of a vector

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - state=IDLE, chunk counter cnt=0, holding register=0.
  - data_out_valid=0, data_out_last=0, data_out all zero.
  - A vector in flight is discarded and no partial chunks are emitted after release.
- Handshakes:
  - Input fire: in_fire = data_in_valid & data_in_ready.
  - Output fire: out_fire = data_out_valid & data_out_ready.
- States:
  - IDLE: data_out_valid=0, data_in_ready=1. On in_fire, load holding register, set cnt=0, go to SEND.
  - SEND: data_out_valid=1. data_out[j] = hold[cnt*OUT_NUM + j] for j = 0..OUT_NUM-1. data_out_last = (cnt==RATIO-1).
    - On out_fire with cnt<RATIO-1: cnt++.
    - On out_fire with cnt==RATIO-1: if in_fire in the same cycle, reload the holding register, cnt=0, stay in SEND (no bubble); else cnt=0, go to IDLE.
- data_in_ready = (state==IDLE) | (state==SEND & cnt==RATIO-1 & data_out_ready). This is combinational from data_out_ready, which is permitted. There is no combinational path from data_in_valid to data_out_valid.
- Latency: the first chunk is valid one cycle after in_fire.
- Throughput: one vector per RATIO cycles sustained when data_out_ready stays high.
- Stall: while data_out_valid=1 and data_out_ready=0, data_out, data_out_last and cnt hold stable.
- Ordering: element 0 leaves first; chunks go in ascending element index.
- Counter width: $clog2(RATIO), minimum 1 bit. Wrap occurs only via the last-chunk rule above.
- RATIO=1: behaves as a single-entry registered pipeline stage. data_out_last is always 1 when valid, and the back-to-back reload rule still applies.
- data_in is ignored whenever in_fire=0.

Decomposition:
- Shared package (common_pkg): serializer state enum {IDLE, SEND}.
- Everything else (RATIO, counter width) is a local parameter.
- No sub-module. The chunk select is an indexed part-select on a flattened holding register, using the same flatten/unflatten idiom as the FIFO.

Test Plan:
1. Reset release, no input, 5 cycles -> data_out_valid=0, data_in_ready=1, data_out=0.
2. Defaults, vector {0..7} (element i = i), data_out_ready=1 -> chunks {0,1},{2,3},{4,5},{6,7} on cycles 1-4 after in_fire; last=1 only on {6,7}.
3. Two vectors back-to-back, data_in_valid held high, data_out_ready=1 -> 8 consecutive valid cycles with no bubble; second vector's first chunk follows immediately after first's last chunk.
4. data_out_ready toggles 1,0,0,1,... during a vector -> each chunk held stable through stalls; all four chunks delivered exactly once, in order; data_in_ready=0 until the last-chunk handshake.
5. rst pulled low asynchronously mid-vector (after chunk 2) -> data_out_valid drops without a clock edge; after release, no residual chunks; the next vector {8..15} starts at {8,9}.
6. OUT_NUM=8 (RATIO=1) with a random stream and random data_out_ready -> output equals input order, data_out_last always 1, full throughput when ready is held high.

Source files
------------

// File: rtl/common_pkg.sv
// Types shared by the streaming datapath blocks.
// The serializer FSM has an idle state and a chunk-sending state.
package common_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vector_serializer.sv
// Splits each IN_NUM-element input vector into IN_NUM/OUT_NUM chunks of OUT_NUM
// elements, element 0 first, with a no-bubble reload on the final chunk.
module vector_serializer
  import common_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int RATIO   = IN_NUM / OUT_NUM;
  localparam int CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CHUNK_W = DATA_WIDTH * OUT_NUM;
  localparam int HOLD_W  = DATA_WIDTH * IN_NUM;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if (IN_NUM % OUT_NUM != 0) begin : g_bad_ratio
      $error("vector_serializer: IN_NUM must be a multiple of OUT_NUM");
    end
  endgenerate

  ser_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_data_in_flat;
  logic [CHUNK_W-1:0] w_chunk;
  logic               w_at_last;
  logic               w_in_fire;
  logic               w_out_fire;

  genvar gi;
  generate
    for (gi = 0; gi < IN_NUM; gi++) begin : g_flatten
      assign w_data_in_flat[gi*DATA_WIDTH +: DATA_WIDTH] = data_in[gi];
    end
    for (gi = 0; gi < OUT_NUM; gi++) begin : g_unflatten
      assign data_out[gi] = w_chunk[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_at_last      = (r_cnt == LAST_CNT);
  assign data_out_valid = (r_state == SEND);
  assign data_out_last  = data_out_valid & w_at_last;
  // Ready on the final chunk lets the next vector load in the same cycle.
  assign data_in_ready  = (r_state == IDLE) | (data_out_valid & w_at_last & data_out_ready);
  assign w_in_fire      = data_in_valid & data_in_ready;
  assign w_out_fire     = data_out_valid & data_out_ready;
  assign w_chunk        = r_hold[r_cnt*CHUNK_W +: CHUNK_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_hold  <= w_data_in_flat;
            r_cnt   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_out_fire) begin
            if (!w_at_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt <= '0;
              if (w_in_fire) begin
                r_hold <= w_data_in_flat;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
